// File: rtl/gearbox_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gearbox_pkg
//  Description : Derived-size helpers and parameter legality for gearbox_fifo.
//  Revision    : 1.0 - initial release
// ============================================================================
package gearbox_pkg;

    function automatic int narrow_width(input int w, input int r);
        return (w < r) ? w : r;
    endfunction

    function automatic int ratio_k(input int w, input int r);
        return ((w > r) ? w : r) / narrow_width(w, r);
    endfunction

    function automatic int units_of(input int width, input int w, input int r);
        return width / narrow_width(w, r);
    endfunction

    function automatic int ptr_width(input int storage);
        return (storage > 1) ? $clog2(storage) : 1;
    endfunction

    function automatic int count_width(input int storage);
        return $clog2(storage) + 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit params_legal(input int w, input int r, input int depth);
        if (w <= 0 || r <= 0) return 1'b0;
        if ((((w > r) ? w : r) % narrow_width(w, r)) != 0) return 1'b0;
        return is_pow2(depth) && (depth >= 2);
    endfunction

    // Storage may hold a non-power-of-two unit count, so wrap explicitly.
    function automatic int wrap_add(input int ptr, input int step, input int storage);
        int sum;
        sum = ptr + step;
        return (sum >= storage) ? (sum - storage) : sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gearbox_ram.sv
`default_nettype none
// ============================================================================
//  Module      : gearbox_ram
//  Description : Circular narrow-unit store, multi-unit write and read ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module gearbox_ram
    import gearbox_pkg::*;
#(
    parameter int UNIT_WIDTH = 16,
    parameter int STORAGE    = 32,
    parameter int WR_UNITS   = 4,
    parameter int RD_UNITS   = 1,
    parameter int PTR_W      = 5
) (
    input  logic                           clk,
    input  logic                           wr_en,
    input  logic [PTR_W-1:0]               wr_ptr,
    input  logic [WR_UNITS*UNIT_WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0]               rd_ptr,
    output logic [RD_UNITS*UNIT_WIDTH-1:0] rd_data
);

    logic [STORAGE-1:0][UNIT_WIDTH-1:0] mem;
    logic [STORAGE-1:0][UNIT_WIDTH-1:0] mem_next;

    // Slice i of the write word lands i units after the write pointer.
    always_comb begin
        mem_next = mem;
        if (wr_en) begin
            for (int i = 0; i < WR_UNITS; i++) begin
                mem_next[PTR_W'(wrap_add(int'(wr_ptr), i, STORAGE))] =
                    wr_data[i*UNIT_WIDTH +: UNIT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        mem <= mem_next;
    end

    for (genvar j = 0; j < RD_UNITS; j++) begin : g_rd_slice
        assign rd_data[j*UNIT_WIDTH +: UNIT_WIDTH] =
            mem[PTR_W'(wrap_add(int'(rd_ptr), j, STORAGE))];
    end

endmodule
`default_nettype wire

// File: rtl/gearbox_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : gearbox_fifo
//  Description : Width-converting FIFO with thresholds, flush and sticky errors.
//                GEARBOX_FWFT_EN selects first-word-fall-through read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module gearbox_fifo
    import gearbox_pkg::*;
#(
    parameter int W_DATA_WIDTH = 64,
    parameter int R_DATA_WIDTH = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int AF_THRESH    = 1,
    parameter int AE_THRESH    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    write_request,
    input  logic [W_DATA_WIDTH-1:0] wr_data,
    input  logic                    read_request,
    output logic [R_DATA_WIDTH-1:0] rd_data,
    output logic                    full_flag,
    output logic                    empty_flag,
    output logic                    almost_full_flag,
    output logic                    almost_empty_flag,
    output logic [count_width(FIFO_DEPTH*ratio_k(W_DATA_WIDTH, R_DATA_WIDTH))-1:0] fill_count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int N       = narrow_width(W_DATA_WIDTH, R_DATA_WIDTH);
    localparam int K       = ratio_k(W_DATA_WIDTH, R_DATA_WIDTH);
    localparam int W_UNITS = units_of(W_DATA_WIDTH, W_DATA_WIDTH, R_DATA_WIDTH);
    localparam int R_UNITS = units_of(R_DATA_WIDTH, W_DATA_WIDTH, R_DATA_WIDTH);
    localparam int STORAGE = FIFO_DEPTH * K;
    localparam int PTR_W   = ptr_width(STORAGE);
    localparam int CNT_W   = count_width(STORAGE);

    localparam logic [31:0] STORAGE_L  = 32'(STORAGE);
    localparam logic [31:0] W_UNITS_L  = 32'(W_UNITS);
    localparam logic [31:0] R_UNITS_L  = 32'(R_UNITS);
    localparam logic [31:0] AF_LIMIT_L = 32'(W_UNITS + AF_THRESH * W_UNITS);
    localparam logic [31:0] AE_LIMIT_L = 32'(R_UNITS + AE_THRESH * R_UNITS);
    localparam logic [CNT_W-1:0] W_UNITS_C = CNT_W'(W_UNITS);
    localparam logic [CNT_W-1:0] R_UNITS_C = CNT_W'(R_UNITS);

    if (!params_legal(W_DATA_WIDTH, R_DATA_WIDTH, FIFO_DEPTH)) begin : g_param_error
        $error("gearbox_fifo: illegal width ratio or FIFO_DEPTH");
    end

    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [R_DATA_WIDTH-1:0] head_word;
    logic [31:0]             fill_ext;
    logic [31:0]             free_ext;
    logic                    wr_accept;
    logic                    rd_accept;

    assign fill_ext = 32'(fill_count);
    assign free_ext = STORAGE_L - fill_ext;

    // Occupancy alone decides the flags, so pointer wrap never aliases full/empty.
    assign full_flag         = free_ext < W_UNITS_L;
    assign empty_flag        = fill_ext < R_UNITS_L;
    assign almost_full_flag  = free_ext < AF_LIMIT_L;
    assign almost_empty_flag = fill_ext < AE_LIMIT_L;

    assign wr_accept = write_request && !full_flag && !flush;
    assign rd_accept = read_request && !empty_flag && !flush;

    gearbox_ram #(
        .UNIT_WIDTH (N),
        .STORAGE    (STORAGE),
        .WR_UNITS   (W_UNITS),
        .RD_UNITS   (R_UNITS),
        .PTR_W      (PTR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_ptr  (wr_ptr),
        .wr_data (wr_data),
        .rd_ptr  (rd_ptr),
        .rd_data (head_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_count <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_count <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (wr_accept) wr_ptr <= PTR_W'(wrap_add(int'(wr_ptr), W_UNITS, STORAGE));
            if (rd_accept) rd_ptr <= PTR_W'(wrap_add(int'(rd_ptr), R_UNITS, STORAGE));
            fill_count <= fill_count + (wr_accept ? W_UNITS_C : '0)
                                     - (rd_accept ? R_UNITS_C : '0);
            if (write_request && full_flag) overflow  <= 1'b1;
            if (read_request && empty_flag) underflow <= 1'b1;
        end
    end

`ifdef GEARBOX_FWFT_EN
    assign rd_data = empty_flag ? '0 : head_word;
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_accept) begin
            rd_data <= head_word;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_gearbox_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gearbox_fifo
//  Description : Queue-model bench for a 64->16 and a 16->64 gearbox_fifo.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gearbox_fifo;

    localparam int UNIT  = 16;
    localparam int STORE = 32;
    localparam int AF    = 1;
    localparam int AE    = 1;
`ifdef GEARBOX_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, flush, write_request, read_request, mode;
    logic [63:0] wr_data;

    logic [15:0] dn_rd;
    logic [63:0] up_rd;
    logic [5:0]  dn_fill, up_fill;
    logic dn_full, dn_empty, dn_af, dn_ae, dn_ovf, dn_unf;
    logic up_full, up_empty, up_af, up_ae, up_ovf, up_unf;

    logic [63:0] obs_rd;
    logic [5:0]  obs_fill;
    logic obs_full, obs_empty, obs_af, obs_ae, obs_ovf, obs_unf;

    gearbox_fifo #(.W_DATA_WIDTH(64), .R_DATA_WIDTH(16), .FIFO_DEPTH(8),
                   .AF_THRESH(AF), .AE_THRESH(AE)) dut_dn (
        .clk(clk), .reset(reset), .flush(flush),
        .write_request(write_request & ~mode), .wr_data(wr_data),
        .read_request(read_request & ~mode), .rd_data(dn_rd),
        .full_flag(dn_full), .empty_flag(dn_empty),
        .almost_full_flag(dn_af), .almost_empty_flag(dn_ae),
        .fill_count(dn_fill), .overflow(dn_ovf), .underflow(dn_unf));

    gearbox_fifo #(.W_DATA_WIDTH(16), .R_DATA_WIDTH(64), .FIFO_DEPTH(8),
                   .AF_THRESH(AF), .AE_THRESH(AE)) dut_up (
        .clk(clk), .reset(reset), .flush(flush),
        .write_request(write_request & mode), .wr_data(wr_data[15:0]),
        .read_request(read_request & mode), .rd_data(up_rd),
        .full_flag(up_full), .empty_flag(up_empty),
        .almost_full_flag(up_af), .almost_empty_flag(up_ae),
        .fill_count(up_fill), .overflow(up_ovf), .underflow(up_unf));

    assign obs_rd    = mode ? up_rd    : {48'd0, dn_rd};
    assign obs_fill  = mode ? up_fill  : dn_fill;
    assign obs_full  = mode ? up_full  : dn_full;
    assign obs_empty = mode ? up_empty : dn_empty;
    assign obs_af    = mode ? up_af    : dn_af;
    assign obs_ae    = mode ? up_ae    : dn_ae;
    assign obs_ovf   = mode ? up_ovf   : dn_ovf;
    assign obs_unf   = mode ? up_unf   : dn_unf;

    always #5 clk = ~clk;

    // Reference model: a queue of narrow units, oldest at the front.
    logic [15:0] mq[$];
    logic [63:0] m_rd;
    logic        m_ovf, m_unf;
    int          wu, ru;
    int          total, bad;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        int          sz;
        logic [63:0] exp_rd;
        sz     = mq.size();
        exp_rd = m_rd;
        if (FWFT) begin
            exp_rd = '0;
            if (sz >= ru)
                for (int j = 0; j < ru; j++) exp_rd[j*UNIT +: UNIT] = mq[j];
        end
        check_value("fill_count",   64'(obs_fill),  64'(sz));
        check_value("full_flag",    64'(obs_full),  64'((STORE - sz) < wu));
        check_value("empty_flag",   64'(obs_empty), 64'(sz < ru));
        check_value("almost_full",  64'(obs_af),    64'((STORE - sz) < (wu + AF * wu)));
        check_value("almost_empty", 64'(obs_ae),    64'(sz < (ru + AE * ru)));
        check_value("overflow",     64'(obs_ovf),   64'(m_ovf));
        check_value("underflow",    64'(obs_unf),   64'(m_unf));
        check_value("rd_data",      obs_rd,         exp_rd);
    endtask

    // Called at a falling edge; returns at the next falling edge after checking.
    task automatic cycle(input logic wr, input logic [63:0] wd, input logic rd, input logic fl);
        logic m_full, m_empty;
        m_full  = (STORE - mq.size()) < wu;
        m_empty = mq.size() < ru;
        write_request = wr;
        wr_data       = wd;
        read_request  = rd;
        flush         = fl;
        @(posedge clk);
        if (fl) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (wr && m_full) m_ovf = 1'b1;
            if (rd && m_empty) m_unf = 1'b1;
            if (rd && !m_empty) begin
                m_rd = '0;
                for (int j = 0; j < ru; j++) m_rd[j*UNIT +: UNIT] = mq.pop_front();
            end
            if (wr && !m_full)
                for (int j = 0; j < wu; j++) mq.push_back(wd[j*UNIT +: UNIT]);
        end
        @(negedge clk);
        write_request = 1'b0;
        read_request  = 1'b0;
        flush         = 1'b0;
        check_model();
    endtask

    task automatic random_run(input int cycles, input int wr_pct, input int rd_pct);
        for (int c = 0; c < cycles; c++)
            cycle($urandom_range(0, 99) < wr_pct, {$urandom, $urandom},
                  $urandom_range(0, 99) < rd_pct, $urandom_range(0, 99) < 2);
    endtask

    task automatic model_reset();
        mq.delete();
        m_rd  = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic mid_reset();
        write_request = 1'b1;
        read_request  = 1'b1;
        wr_data       = {$urandom, $urandom};
        #2 reset = 1'b1;
        #1 model_reset();
        check_model();
        #1 reset = 1'b0;
        write_request = 1'b0;
        read_request  = 1'b0;
        @(negedge clk);
        check_model();
    endtask

    initial begin
        logic [63:0] exp_lit;
        total = 0;
        bad   = 0;
        mode  = 1'b0;
        wu    = 4;
        ru    = 1;
        reset = 1'b1;
        flush = 1'b0;
        write_request = 1'b0;
        read_request  = 1'b0;
        wr_data = '0;
        model_reset();
        #3 check_model();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_model();

        // Downsize: one wide word comes back as four slices, oldest first.
        cycle(1'b1, 64'h0004_0003_0002_0001, 1'b0, 1'b0);
        check_value("dn_head_before_read", obs_rd, FWFT ? 64'h1 : 64'h0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            exp_lit = FWFT ? ((i < 3) ? 64'(i + 2) : 64'h0) : 64'(i + 1);
            check_value("dn_slice", obs_rd, exp_lit);
        end
        check_value("dn_empty_after_4", 64'(obs_empty), 64'h1);

        // Fill to capacity, overflow, then read/write across the pointer wrap.
        for (int i = 0; i < 8; i++) cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        check_value("dn_fill_full", 64'(obs_fill), 64'd32);
        check_value("dn_full", 64'(obs_full), 64'h1);
        cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        check_value("dn_overflow", 64'(obs_ovf), 64'h1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        // Simultaneous read and write at fill_count=8.
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        cycle(1'b1, {$urandom, $urandom}, 1'b1, 1'b0);
        check_value("dn_simul_fill", 64'(obs_fill), 64'd11);

        // Underflow from empty, then flush racing a write.
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_value("dn_underflow", 64'(obs_unf), 64'h1);
        cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b1);
        check_value("dn_flush_fill", 64'(obs_fill), 64'd0);
        check_value("dn_flush_unf", 64'(obs_unf), 64'h0);

        random_run(300, 35, 60);
        for (int i = 0; i < 3; i++) cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        mid_reset();
        random_run(100, 35, 60);

        // Upsize: four narrow writes assemble one wide read word.
        cycle(1'b0, '0, 1'b0, 1'b1);
        mode = 1'b1;
        wu   = 1;
        ru   = 4;
        m_rd = {48'd0, dn_rd};
        @(negedge clk);
        m_rd = up_rd;
        check_model();
        for (int i = 1; i <= 3; i++) cycle(1'b1, 64'(i), 1'b0, 1'b0);
        check_value("up_partial_empty", 64'(obs_empty), 64'h1);
        cycle(1'b1, 64'h4, 1'b0, 1'b0);
        check_value("up_word_ready", 64'(obs_empty), 64'h0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_value("up_word", obs_rd, FWFT ? 64'h0 : 64'h0004_0003_0002_0001);

        random_run(300, 75, 25);
        mid_reset();
        random_run(100, 75, 25);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
